lsb_queue: RTL and testbench

- In-order load/store buffer directly downstream of the single-entry store/load reservation station.
- Accepts operand-resolved memory ops from the station and computes the effective address at enqueue.
- Issues ops one at a time to the memory controller. Loads issue from the head immediately; stores issue only after ROB commit.
- Broadcasts load results and store-ready notifications back toward the ROB.

---
 rtl/lsb_queue_pkg.sv | 32 +++
 rtl/lsb_queue_if.sv | 40 ++++
 rtl/lsb_queue_load_ext.sv | 21 ++
 rtl/lsb_queue.sv | 242 ++++++++++++++++++++++++
 tb/tb_lsb_queue.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsb_queue_pkg.sv
// Shared types and constants for the load/store buffer: opcodes, access widths,
// the queue entry layout and the issue FSM states.
package lsb_queue_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef struct packed {
        logic        valid;
        logic        is_store;
        logic        committed;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  funct3;
        logic [4:0]  rob_id;
    } entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/lsb_queue_if.sv
// Station/ROB/memory-side signals of the load/store buffer. The queue itself
// uses the slave modport; its environment uses master.
interface lsb_queue_if;
    logic        en_i;
    logic [31:0] A_i;
    logic [31:0] B_i;
    logic [31:0] Imm_i;
    logic [6:0]  OP_i;
    logic [2:0]  Funct3_i;
    logic [4:0]  ROB_id_i;
    logic        full_o;
    logic        commit_en_i;
    logic [4:0]  commit_ROB_id_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [2:0]  mem_funct3_o;
    logic        mem_done_i;
    logic [31:0] mem_data_i;
    logic        cdb_en_o;
    logic [4:0]  cdb_ROB_id_o;
    logic [31:0] cdb_data_o;
    logic        st_rdy_o;
    logic [4:0]  st_rdy_ROB_id_o;

    modport master (
        output en_i, A_i, B_i, Imm_i, OP_i, Funct3_i, ROB_id_i,
        output commit_en_i, commit_ROB_id_i, mem_done_i, mem_data_i,
        input  full_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o, mem_funct3_o,
        input  cdb_en_o, cdb_ROB_id_o, cdb_data_o, st_rdy_o, st_rdy_ROB_id_o
    );

    modport slave (
        input  en_i, A_i, B_i, Imm_i, OP_i, Funct3_i, ROB_id_i,
        input  commit_en_i, commit_ROB_id_i, mem_done_i, mem_data_i,
        output full_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o, mem_funct3_o,
        output cdb_en_o, cdb_ROB_id_o, cdb_data_o, st_rdy_o, st_rdy_ROB_id_o
    );
endinterface

// File: rtl/lsb_queue_load_ext.sv
// Sign/zero extension of right-aligned raw load data according to funct3.
module lsb_load_ext
    import lsb_queue_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_funct3)
            LB:      o_data = {{24{i_data[7]}}, i_data[7:0]};
            LH:      o_data = {{16{i_data[15]}}, i_data[15:0]};
            LBU:     o_data = {24'h0, i_data[7:0]};
            LHU:     o_data = {16'h0, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/lsb_queue.sv
// In-order load/store buffer: loads issue from the head at once, stores wait for
// ROB commit. Optional LSB_PERF_EN adds saturating load/store/full counters.
module lsb_queue
    import lsb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rst_c,
    input  logic        rdy,
    lsb_queue_if.slave  bus
`ifdef LSB_PERF_EN
    ,
    output logic [31:0] perf_ld_o,
    output logic [31:0] perf_st_o,
    output logic [31:0] perf_full_o
`endif
);

    entry_t             r_entries [DEPTH];
    logic [IDX_W-1:0]   r_head;
    logic [IDX_W-1:0]   r_tail;
    logic [IDX_W:0]     r_count;
    state_t             r_state;
    logic               r_killed;
    logic               r_fly_store;
    logic [2:0]         r_fly_f3;
    logic [4:0]         r_fly_rob;

    logic               r_mem_req;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_data;
    logic [2:0]         r_mem_f3;
    logic               r_cdb_en;
    logic [4:0]         r_cdb_rob;
    logic [31:0]        r_cdb_data;
    logic               r_st_rdy;
    logic [4:0]         r_st_rdy_rob;

    entry_t             w_head;
    entry_t             w_new_entry;
    logic               w_is_store;
    logic               w_is_load;
    logic               w_enq;
    logic               w_pop;
    logic               w_issue;
    logic [IDX_W+1:0]   w_occ;
    logic [IDX_W:0]     w_keep;
    logic [IDX_W:0]     w_keep_after;
    logic [IDX_W-1:0]   w_fl_head;
    logic [DEPTH-1:0]   w_commit_hit;
    logic [DEPTH-1:0]   w_keep_mask;
    logic [31:0]        w_ext_data;

    assign w_head      = r_entries[r_head];
    assign w_is_store  = (bus.OP_i == OP_STORE);
    assign w_is_load   = (bus.OP_i == OP_LOAD);
    assign w_enq       = bus.en_i && (w_is_store || w_is_load) && !rst_c
                         && (r_count != (IDX_W+1)'(DEPTH));
    assign w_pop       = (r_state == WAIT) && bus.mem_done_i && !r_killed;
    assign w_issue     = (r_state == IDLE) && !rst_c && w_head.valid
                         && (!w_head.is_store || w_head.committed);

    // Full one slot early so an enqueue already in flight from the station still fits.
    assign w_occ       = {1'b0, r_count} + (IDX_W+2)'(bus.en_i);
    assign bus.full_o  = (w_occ >= (IDX_W+2)'(DEPTH - 1));

    always_comb begin
        w_new_entry           = '0;
        w_new_entry.valid     = 1'b1;
        w_new_entry.is_store  = w_is_store;
        w_new_entry.committed = w_is_store && bus.commit_en_i
                                && (bus.commit_ROB_id_i == bus.ROB_id_i);
        w_new_entry.addr      = bus.A_i + bus.Imm_i;
        w_new_entry.data      = bus.B_i;
        w_new_entry.funct3    = bus.Funct3_i;
        w_new_entry.rob_id    = bus.ROB_id_i;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [IDX_W-1:0] w_off;
            assign w_off            = IDX_W'(gi) - r_head;
            assign w_keep_mask[gi]  = ({1'b0, w_off} < w_keep);
            assign w_commit_hit[gi] = r_entries[gi].valid && r_entries[gi].is_store
                                      && bus.commit_en_i
                                      && (r_entries[gi].rob_id == bus.commit_ROB_id_i);
        end
    endgenerate

    // Length of the run of committed stores starting at the head survives a flush.
    always_comb begin
        logic             run;
        logic [IDX_W-1:0] idx;
        w_keep = '0;
        run    = 1'b1;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_head + IDX_W'(k);
            if (run && r_entries[idx].valid && r_entries[idx].is_store
                && (r_entries[idx].committed || w_commit_hit[idx]))
                w_keep = w_keep + (IDX_W+1)'(1);
            else
                run = 1'b0;
        end
    end

    assign w_keep_after = (w_keep == '0) ? '0 : (w_keep - (IDX_W+1)'(w_pop));
    assign w_fl_head    = r_head + IDX_W'(w_pop);

    lsb_load_ext u_load_ext (
        .i_funct3 (r_fly_f3),
        .i_data   (bus.mem_data_i),
        .o_data   (w_ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_state      <= IDLE;
            r_killed     <= 1'b0;
            r_fly_store  <= 1'b0;
            r_fly_f3     <= '0;
            r_fly_rob    <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_mem_f3     <= '0;
            r_cdb_en     <= 1'b0;
            r_cdb_rob    <= '0;
            r_cdb_data   <= '0;
            r_st_rdy     <= 1'b0;
            r_st_rdy_rob <= '0;
        end else if (rdy) begin
            r_mem_req <= 1'b0;
            r_cdb_en  <= 1'b0;
            r_st_rdy  <= 1'b0;

            for (int i = 0; i < DEPTH; i++)
                if (w_commit_hit[i]) r_entries[i].committed <= 1'b1;
            if (w_pop) r_entries[r_head].valid <= 1'b0;

            if (rst_c) begin
                for (int i = 0; i < DEPTH; i++)
                    if (!w_keep_mask[i]) r_entries[i].valid <= 1'b0;
                r_head  <= w_fl_head;
                r_tail  <= w_fl_head + w_keep_after[IDX_W-1:0];
                r_count <= w_keep_after;
            end else begin
                if (w_enq) begin
                    r_entries[r_tail] <= w_new_entry;
                    r_tail            <= r_tail + 1'b1;
                    if (w_is_store) begin
                        r_st_rdy     <= 1'b1;
                        r_st_rdy_rob <= bus.ROB_id_i;
                    end
                end
                if (w_pop) r_head <= r_head + 1'b1;
                r_count <= r_count + (IDX_W+1)'(w_enq) - (IDX_W+1)'(w_pop);
            end

            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_head.is_store;
                        r_mem_addr  <= w_head.addr;
                        r_mem_data  <= w_head.data;
                        r_mem_f3    <= w_head.funct3;
                        r_fly_store <= w_head.is_store;
                        r_fly_f3    <= w_head.funct3;
                        r_fly_rob   <= w_head.rob_id;
                        r_killed    <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_done_i) begin
                        r_state  <= IDLE;
                        r_killed <= 1'b0;
                        if (!r_fly_store && !r_killed && !rst_c) begin
                            r_cdb_en   <= 1'b1;
                            r_cdb_rob  <= r_fly_rob;
                            r_cdb_data <= w_ext_data;
                        end
                    end else if (rst_c && !r_fly_store) begin
                        // Memory still owes us this access; wait it out but drop the result.
                        r_killed <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req_o       = r_mem_req;
    assign bus.mem_we_o        = r_mem_we;
    assign bus.mem_addr_o      = r_mem_addr;
    assign bus.mem_data_o      = r_mem_data;
    assign bus.mem_funct3_o    = r_mem_f3;
    assign bus.cdb_en_o        = r_cdb_en;
    assign bus.cdb_ROB_id_o    = r_cdb_rob;
    assign bus.cdb_data_o      = r_cdb_data;
    assign bus.st_rdy_o        = r_st_rdy;
    assign bus.st_rdy_ROB_id_o = r_st_rdy_rob;

`ifdef LSB_PERF_EN
    logic [31:0] r_perf_ld;
    logic [31:0] r_perf_st;
    logic [31:0] r_perf_full;
    logic        w_done;

    assign w_done = (r_state == WAIT) && bus.mem_done_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_ld   <= '0;
            r_perf_st   <= '0;
            r_perf_full <= '0;
        end else if (rdy) begin
            if (w_done && !r_fly_store && (r_perf_ld != 32'hFFFFFFFF))
                r_perf_ld <= r_perf_ld + 32'd1;
            if (w_done && r_fly_store && (r_perf_st != 32'hFFFFFFFF))
                r_perf_st <= r_perf_st + 32'd1;
            if (bus.full_o && (r_perf_full != 32'hFFFFFFFF))
                r_perf_full <= r_perf_full + 32'd1;
        end
    end

    assign perf_ld_o   = r_perf_ld;
    assign perf_st_o   = r_perf_st;
    assign perf_full_o = r_perf_full;
`endif

endmodule

// File: tb/tb_lsb_queue.sv
// Self-checking bench for lsb_queue: vector table for load/store datapath plus
// directed sequences for ordering, back-pressure, flush, reset and stall.
module tb_lsb_queue;
    import lsb_queue_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rst_c = 1'b0;
    logic rdy   = 1'b0;
    always #5 clk = ~clk;

    lsb_queue_if bus ();

`ifdef LSB_PERF_EN
    logic [31:0] perf_ld, perf_st, perf_full;
`endif

    lsb_queue #(.DEPTH(4), .IDX_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rst_c (rst_c),
        .rdy   (rdy),
        .bus   (bus)
`ifdef LSB_PERF_EN
        ,
        .perf_ld_o   (perf_ld),
        .perf_st_o   (perf_st),
        .perf_full_o (perf_full)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
        logic [31:0] rdata;
    } req_t;

    typedef struct {
        logic [4:0]  rob;
        logic [31:0] data;
    } cdb_t;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] imm;
        logic [31:0] b;
        logic [4:0]  rob;
        logic [31:0] rdata;
        logic [31:0] cdb;
    } vec_t;

    req_t       exp_req [$];
    cdb_t       exp_cdb [$];
    logic [4:0] exp_st  [$];

    int   checks = 0;
    int   errors = 0;
    logic rdy_q  = 1'b0;
    int   resp_delay = 0;
    int   resp_cnt   = 0;
    bit   pending    = 1'b0;
    logic [31:0] resp_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) rdy_q <= rdy;

    // Monitor + memory model: compares every DUT strobe against the scoreboard
    // and answers each request after resp_delay rdy cycles.
    always @(negedge clk) begin
        req_t r;
        cdb_t c;
        logic [4:0] t;
        if (!rst_n) begin
            pending        = 1'b0;
            bus.mem_done_i = 1'b0;
            bus.mem_data_i = '0;
        end else begin
            bus.mem_done_i = 1'b0;
            if (rdy_q && bus.mem_req_o) begin
                if (exp_req.size() == 0) begin
                    chk("unexpected_mem_req", bus.mem_addr_o, 32'hxxxx_xxxx);
                end else begin
                    r = exp_req.pop_front();
                    chk("req_we", {31'h0, bus.mem_we_o}, {31'h0, r.we});
                    chk("req_addr", bus.mem_addr_o, r.addr);
                    chk("req_funct3", {29'h0, bus.mem_funct3_o}, {29'h0, r.f3});
                    if (r.we) chk("req_store_data", bus.mem_data_o, r.data);
                    $display("mem_req we=%0b addr=%h f3=%0d", bus.mem_we_o, bus.mem_addr_o, bus.mem_funct3_o);
                    pending   = 1'b1;
                    resp_cnt  = resp_delay;
                    resp_data = r.rdata;
                end
            end
            if (rdy_q && bus.cdb_en_o) begin
                if (exp_cdb.size() == 0) begin
                    chk("unexpected_cdb", {27'h0, bus.cdb_ROB_id_o}, 32'hxxxx_xxxx);
                end else begin
                    c = exp_cdb.pop_front();
                    chk("cdb_rob", {27'h0, bus.cdb_ROB_id_o}, {27'h0, c.rob});
                    chk("cdb_data", bus.cdb_data_o, c.data);
                    $display("cdb rob=%0d data=%h", bus.cdb_ROB_id_o, bus.cdb_data_o);
                end
            end
            if (rdy_q && bus.st_rdy_o) begin
                if (exp_st.size() == 0) begin
                    chk("unexpected_st_rdy", {27'h0, bus.st_rdy_ROB_id_o}, 32'hxxxx_xxxx);
                end else begin
                    t = exp_st.pop_front();
                    chk("st_rdy_rob", {27'h0, bus.st_rdy_ROB_id_o}, {27'h0, t});
                    $display("st_rdy rob=%0d", bus.st_rdy_ROB_id_o);
                end
            end
            if (pending && rdy) begin
                if (resp_cnt == 0) begin
                    bus.mem_done_i = 1'b1;
                    bus.mem_data_i = resp_data;
                    pending        = 1'b0;
                end else begin
                    resp_cnt--;
                end
            end
        end
    end

    always @(posedge clk)
        if (rst_n && rdy && bus.en_i)
            assert (dut.r_count != 3'd4) else $error("en_i presented while queue holds DEPTH entries");

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] imm,
                                input logic [31:0] b, input logic [4:0] rob,
                                input logic [31:0] rdata, input logic [31:0] cdb);
        vec_t v;
        v.op = op; v.f3 = f3; v.a = a; v.imm = imm; v.b = b;
        v.rob = rob; v.rdata = rdata; v.cdb = cdb;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input vec_t v, input int exp_full, input bit commit_now);
        req_t r;
        cdb_t c;
        bus.OP_i     = v.op;
        bus.Funct3_i = v.f3;
        bus.A_i      = v.a;
        bus.Imm_i    = v.imm;
        bus.B_i      = v.b;
        bus.ROB_id_i = v.rob;
        bus.en_i     = 1'b1;
        if (commit_now) begin
            bus.commit_en_i     = 1'b1;
            bus.commit_ROB_id_i = v.rob;
        end
        r.we = (v.op == OP_STORE); r.addr = v.a + v.imm; r.data = v.b; r.f3 = v.f3;
        r.rdata = (v.op == OP_STORE) ? 32'h0 : v.rdata;
        exp_req.push_back(r);
        if (v.op == OP_STORE) begin
            exp_st.push_back(v.rob);
        end else begin
            c.rob = v.rob; c.data = v.cdb;
            exp_cdb.push_back(c);
        end
        #1;
        if (exp_full >= 0) chk("full_o_during_enq", {31'h0, bus.full_o}, exp_full);
        @(posedge clk);
        #1;
        bus.en_i        = 1'b0;
        bus.commit_en_i = 1'b0;
    endtask

    task automatic commit(input logic [4:0] rob);
        bus.commit_en_i     = 1'b1;
        bus.commit_ROB_id_i = rob;
        tick();
        bus.commit_en_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_req.size() != 0 || exp_cdb.size() != 0 || exp_st.size() != 0
                || pending || bus.mem_done_i) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("drain_timeout", n, 0);
        repeat (3) tick();
    endtask

    task automatic flush();
        req_t keep [$];
        rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        foreach (exp_req[i]) if (exp_req[i].we) keep.push_back(exp_req[i]);
        exp_req = keep;
        exp_cdb.delete();
    endtask

    vec_t vt [8];

    initial begin
        int n;
        vt[0] = mk(OP_LOAD,  LB,  32'h0000_2000, 32'hFFFF_FFFC, 32'h0, 5'd7,  32'h0000_0080, 32'hFFFF_FF80);
        vt[1] = mk(OP_LOAD,  LBU, 32'h0000_2000, 32'h0000_0001, 32'h0, 5'd8,  32'h0000_0080, 32'h0000_0080);
        vt[2] = mk(OP_LOAD,  LH,  32'h0000_3000, 32'h0000_0002, 32'h0, 5'd9,  32'h0000_8001, 32'hFFFF_8001);
        vt[3] = mk(OP_LOAD,  LHU, 32'h0000_3000, 32'h0000_0006, 32'h0, 5'd10, 32'h1234_8001, 32'h0000_8001);
        vt[4] = mk(OP_LOAD,  LB,  32'h0000_0000, 32'h0000_0000, 32'h0, 5'd11, 32'hFFFF_FF7F, 32'h0000_007F);
        vt[5] = mk(OP_STORE, SW,  32'hFFFF_FFF0, 32'h0000_0020, 32'hCAFE_F00D, 5'd20, 32'h0, 32'h0);
        vt[6] = mk(OP_STORE, SH,  32'h0000_0010, 32'h0000_0002, 32'h0000_BEEF, 5'd21, 32'h0, 32'h0);
        vt[7] = mk(OP_LOAD,  LW,  32'h0000_4000, 32'h0000_0000, 32'h0, 5'd22, 32'h0BAD_F00D, 32'h0BAD_F00D);

        bus.en_i = 1'b0; bus.A_i = '0; bus.B_i = '0; bus.Imm_i = '0;
        bus.OP_i = '0; bus.Funct3_i = '0; bus.ROB_id_i = '0;
        bus.commit_en_i = 1'b0; bus.commit_ROB_id_i = '0;
        rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'h0, bus.mem_req_o}, 0);
        chk("rst_cdb_en", {31'h0, bus.cdb_en_o}, 0);
        chk("rst_st_rdy", {31'h0, bus.st_rdy_o}, 0);
        chk("rst_mem_addr", bus.mem_addr_o, 0);
        chk("rst_full", {31'h0, bus.full_o}, 0);
        rst_n = 1'b1;
        tick();

        // Load path and minimum latency
        enq(mk(OP_LOAD, LW, 32'h1000, 32'h10, 32'h0, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF), 0, 1'b0);
        chk("lat_req_not_yet", {31'h0, bus.mem_req_o}, 0);
        tick();
        chk("lat_req_t_plus_1", {31'h0, bus.mem_req_o}, 1);
        chk("lat_req_addr", bus.mem_addr_o, 32'h1010);
        drain(50);

        for (int i = 0; i < 8; i++) begin
            enq(vt[i], -1, 1'b0);
            if (vt[i].op == OP_STORE) commit(vt[i].rob);
            drain(50);
        end

        // Store ordering: the store blocks the younger load until it commits
        enq(mk(OP_STORE, SW, 32'h100, 32'h4, 32'h5555AAAA, 5'd5, 32'h0, 32'h0), -1, 1'b0);
        enq(mk(OP_LOAD,  LW, 32'h200, 32'h0, 32'h0, 5'd6, 32'h1234, 32'h1234), -1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("no_req_before_commit", {31'h0, bus.mem_req_o}, 0);
            tick();
        end
        commit(5'd5);
        drain(50);

        // Back-pressure
        enq(mk(OP_STORE, SW, 32'h600, 32'h0, 32'h10, 5'd10, 32'h0, 32'h0), 0, 1'b0);
        chk("full_after_1", {31'h0, bus.full_o}, 0);
        enq(mk(OP_STORE, SW, 32'h604, 32'h0, 32'h11, 5'd11, 32'h0, 32'h0), 0, 1'b0);
        enq(mk(OP_STORE, SW, 32'h608, 32'h0, 32'h12, 5'd12, 32'h0, 32'h0), 1, 1'b0);
        chk("full_after_3", {31'h0, bus.full_o}, 1);
        commit(5'd10);
        n = 0;
        while (bus.full_o && n < 30) begin
            tick();
            n++;
        end
        chk("full_released", {31'h0, bus.full_o}, 0);
        chk("full_release_after_head_store", exp_req.size(), 2);
        commit(5'd11);
        commit(5'd12);
        drain(50);

        // Flush keeps the committed store, drops the loads
        resp_delay = 6;
        enq(mk(OP_STORE, SW, 32'h300, 32'h0, 32'h77, 5'd1, 32'h0, 32'h0), -1, 1'b1);
        enq(mk(OP_LOAD,  LW, 32'h310, 32'h0, 32'h0, 5'd2, 32'h22, 32'h22), -1, 1'b0);
        enq(mk(OP_LOAD,  LW, 32'h320, 32'h0, 32'h0, 5'd4, 32'h44, 32'h44), -1, 1'b0);
        flush();
        drain(60);

        // Killed in-flight load, then normal operation resumes
        resp_delay = 4;
        enq(mk(OP_LOAD, LW, 32'h700, 32'h0, 32'h0, 5'd8, 32'h99, 32'h99), -1, 1'b0);
        tick();
        tick();
        chk("kill_req_seen", exp_req.size(), 0);
        flush();
        drain(40);
        resp_delay = 0;
        enq(mk(OP_LOAD, LW, 32'h704, 32'h0, 32'h0, 5'd9, 32'hA5, 32'hA5), -1, 1'b0);
        drain(40);

        // Asynchronous reset during WAIT
        resp_delay = 8;
        enq(mk(OP_LOAD, LW, 32'h800, 32'h4, 32'h0, 5'd12, 32'h1, 32'h1), -1, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", {31'h0, bus.mem_req_o}, 0);
        chk("async_rst_mem_addr", bus.mem_addr_o, 0);
        chk("async_rst_cdb_rob", {27'h0, bus.cdb_ROB_id_o}, 0);
        chk("async_rst_cdb_data", bus.cdb_data_o, 0);
        exp_req.delete();
        exp_cdb.delete();
        exp_st.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resp_delay = 0;
        tick();
        enq(mk(OP_LOAD, LHU, 32'h40, 32'h4, 32'h0, 5'd13, 32'hFFFF_8000, 32'h0000_8000), -1, 1'b0);
        drain(40);

        // rdy low holds the issued request
        enq(mk(OP_LOAD, LW, 32'h500, 32'h8, 32'h0, 5'd14, 32'h1234_5678, 32'h1234_5678), -1, 1'b0);
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_req_hold", {31'h0, bus.mem_req_o}, 1);
            chk("stall_addr_hold", bus.mem_addr_o, 32'h508);
        end
        rdy = 1'b1;
        drain(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
